// File: rtl/pc_control.sv
// Program-counter sequencer: sequential fetch, taken-branch redirect with a fixed flush window,
// and halt/resume. Define BRANCH_COUNT_EN to add the saturating taken-branch counter output.
module pc_control #(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             salto_i,
  input  logic             branch_valid_i,
  input  logic [WIDTH-1:0] destino_i,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] pc_o,
`ifdef BRANCH_COUNT_EN
  output logic             flush_o,
  output logic [15:0]      contagem_saltos_o
`else
  output logic             flush_o
`endif
);

  typedef enum logic [1:0] {StFetch, StFlush, StHalted} state_e;

  localparam logic [3:0]       FlushLoad = 4'(FLUSH_CYCLES);
  localparam logic [WIDTH-1:0] PcOne     = {{(WIDTH - 1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [3:0]       cnt_q;
  logic             flush_q;
  logic             req_q;
  logic             taken;

  assign taken = branch_valid_i & salto_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StFetch: begin
          // A taken branch wins over halt, stall and imem_ready.
          if (taken) begin
            pc_q    <= destino_i;
            cnt_q   <= FlushLoad;
            state_q <= StFlush;
            flush_q <= 1'b1;
            req_q   <= 1'b0;
          end else if (halt_i) begin
            state_q <= StHalted;
            req_q   <= 1'b0;
          end else if (imem_ready_i && !stall_i) begin
            pc_q <= pc_q + PcOne;
          end
        end
        StFlush: begin
          if (taken) begin
            pc_q  <= destino_i;
            cnt_q <= FlushLoad;
          end else if (cnt_q <= 4'd1) begin
            // Last bubble: a pending halt is honoured only once the flush window closes.
            cnt_q   <= '0;
            flush_q <= 1'b0;
            if (halt_i) begin
              state_q <= StHalted;
              req_q   <= 1'b0;
            end else begin
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHalted: begin
          if (resume_i && !halt_i) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StFetch;
          cnt_q   <= '0;
          flush_q <= 1'b0;
          req_q   <= 1'b1;
        end
      endcase
    end
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] br_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q <= '0;
    end else if (taken && (state_q != StHalted) && (br_cnt_q != 16'hFFFF)) begin
      br_cnt_q <= br_cnt_q + 16'd1;
    end
  end

  assign contagem_saltos_o = br_cnt_q;
`endif

  assign pc_o       = pc_q;
  assign flush_o    = flush_q;
  assign imem_req_o = req_q;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed vector table, then random stimulus against a bubble-count model.
module tb_pc_control;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FC    = 2;

  logic             clk = 1'b0;
  logic             rst, salto, bv, stall, halt, resume, ready;
  logic [WIDTH-1:0] destino;
  logic             imem_req, flush;
  logic [WIDTH-1:0] pc;
`ifdef BRANCH_COUNT_EN
  logic [15:0]      nsaltos;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pc_control #(
    .WIDTH       (WIDTH),
    .RESET_PC    (16'h0000),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .salto_i          (salto),
    .branch_valid_i   (bv),
    .destino_i        (destino),
    .stall_i          (stall),
    .halt_i           (halt),
    .resume_i         (resume),
    .imem_ready_i     (ready),
    .imem_req_o       (imem_req),
    .pc_o             (pc),
`ifdef BRANCH_COUNT_EN
    .flush_o          (flush),
    .contagem_saltos_o(nsaltos)
`else
    .flush_o          (flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, bv, salto, stall, halt, resume, ready;
    logic [15:0] destino;
    logic [15:0] e_pc;
    logic        e_flush, e_req;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, b, s, st, h, rs, rd, input logic [15:0] d,
                     input logic [15:0] epc, input logic ef, er);
    vec_t v;
    v.rst = r; v.bv = b; v.salto = s; v.stall = st; v.halt = h; v.resume = rs; v.ready = rd;
    v.destino = d; v.e_pc = epc; v.e_flush = ef; v.e_req = er;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, b, s, st, h, rs, rd, input logic [15:0] d);
    rst = r; bv = b; salto = s; stall = st; halt = h; resume = rs; ready = rd; destino = d;
  endtask

  // Reference model: remaining flush bubbles, halted flag, pc, branch count.
  int unsigned m_pc, m_bub, m_cnt;
  bit          m_halted;

  task automatic model_step(input logic r, b, s, st, h, rs, rd, input logic [15:0] d);
    bit tk;
    tk = b && s;
    if (r) begin
      m_pc = 0; m_bub = 0; m_halted = 0; m_cnt = 0;
    end else if (m_halted) begin
      if (rs && !h) m_halted = 0;
    end else if (tk) begin
      m_pc = d; m_bub = FC;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_bub > 0) begin
      m_bub--;
      if (m_bub == 0 && h) m_halted = 1;
    end else if (h) begin
      m_halted = 1;
    end else if (rd && !st) begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0);
    //   rst bv s  st h  rs rd destino     pc       fl req
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0002, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0004, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 16'h0999, 16'h0005, 0, 1); // not taken: bv only
    add(0, 0, 1, 0, 0, 0, 1, 16'h0999, 16'h0006, 0, 1); // not taken: salto only
    add(0, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0006, 0, 1); // stall holds
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0006, 0, 1); // not ready holds
    add(0, 1, 1, 1, 0, 0, 0, 16'h0200, 16'h0200, 1, 0); // branch beats stall
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0200, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0200, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0201, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 16'h0300, 16'h0300, 1, 0); // re-branch in flush
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0300, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0300, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1); // wrap
    add(0, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 16'h0040, 16'h0040, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0040, 1, 0); // halt waits for flush
    add(0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0040, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 16'h0500, 16'h0040, 0, 0); // branch ignored halted
    add(0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0040, 0, 0); // halt+resume stays
    add(0, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0040, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0041, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0041, 0, 0); // halt beats ready
    add(1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 1); // reset while halted
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 16'h0700, 16'h0700, 1, 0);
    add(1, 1, 1, 0, 1, 0, 1, 16'h0800, 16'h0000, 0, 1); // reset mid-flush wins
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].bv, tbl[i].salto, tbl[i].stall, tbl[i].halt, tbl[i].resume,
            tbl[i].ready, tbl[i].destino);
      @(posedge clk);
      #1;
      check("tbl_pc", i, 32'(pc), 32'(tbl[i].e_pc));
      check("tbl_flush", i, 32'(flush), 32'(tbl[i].e_flush));
      check("tbl_imem_req", i, 32'(imem_req), 32'(tbl[i].e_req));
    end

    for (int i = 0; i < 3000; i++) begin
      logic r, b, s, st, h, rs, rd;
      logic [15:0] d;
      r  = (i == 0) || ($urandom_range(0, 99) == 0);
      b  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 1) == 0);
      st = ($urandom_range(0, 4) == 0);
      h  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive(r, b, s, st, h, rs, rd, d);
      model_step(r, b, s, st, h, rs, rd, d);
      @(posedge clk);
      #1;
      check("rnd_pc", i, 32'(pc), m_pc);
      check("rnd_flush", i, 32'(flush), 32'(m_bub > 0));
      check("rnd_imem_req", i, 32'(imem_req), 32'(!m_halted && m_bub == 0));
`ifdef BRANCH_COUNT_EN
      check("rnd_branch_count", i, 32'(nsaltos), m_cnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 Parameter WIDTH, default 16, program-counter and branch-target width.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter FLUSH_CYCLES, default 2, range 1..15; number of bubble cycles after a taken branch.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 salto  input  1  branch decision from the condition comparator.
REQ-007 branch_valid  input  1  a branch instruction is in execute; salto is meaningful only while high.
REQ-008 destino  input  WIDTH  branch target address, sampled with branch_valid.
REQ-009 stall  input  1  hold the PC this cycle.
REQ-010 halt  input  1  request to stop fetching.
REQ-011 resume  input  1  leave HALTED.
REQ-012 imem_ready  input  1  instruction memory accepted the current fetch.
REQ-013 imem_req  output  1  fetch request for address pc.
REQ-014 pc  output  WIDTH  current fetch address, registered.
REQ-015 flush  output  1  squash younger instructions this cycle, registered.

Function
REQ-016 Taken branch = branch_valid AND salto, evaluated every cycle.
REQ-017 FSM states: FETCH, FLUSH, HALTED; imem_req = 1 only in FETCH.
REQ-018 FETCH: if imem_ready=1 and stall=0, pc <= pc+1 modulo 2^WIDTH (0xFFFF wraps to 0x0000); otherwise pc holds.
REQ-019 FETCH with taken branch: pc <= destino, state <= FLUSH, flush counter <= FLUSH_CYCLES; taken branch overrides stall, imem_ready and halt in the same cycle.
REQ-020 FLUSH: flush=1, imem_req=0, pc holds; counter decrements each cycle; state <= FETCH in the cycle after counter reaches 1.
REQ-021 Taken branch during FLUSH: pc <= new destino, counter reloaded to FLUSH_CYCLES, state remains FLUSH.
REQ-022 halt=1 in FETCH with no taken branch: state <= HALTED next cycle; pc holds, even if imem_ready=1.
REQ-023 halt=1 during FLUSH: FLUSH completes first, then state <= HALTED if halt is still high.
REQ-024 HALTED: imem_req=0, flush=0, pc holds; taken branches ignored; resume=1 -> FETCH next cycle; halt and resume both high -> remain HALTED.
REQ-025 Latency: taken branch in cycle N -> pc=destino and flush=1 visible in cycle N+1; first fetch of destino in cycle N+1+FLUSH_CYCLES.
REQ-026 Outputs change only on clock edges; no combinational path from inputs to outputs.

Reset
REQ-027 reset=1 at any edge, including mid-FLUSH or HALTED: pc <= RESET_PC, state <= FETCH, counter <= 0, flush <= 0; imem_req=1 in the first cycle after reset deasserts.
REQ-028 reset has priority over every other input.

Configuration
REQ-029 Macro BRANCH_COUNT_EN defined: additional output contagem_saltos (16 bits) counts accepted taken branches (REQ-019, REQ-021), saturates at 0xFFFF, and clears to 0 on reset.
REQ-030 BRANCH_COUNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 Reset, then imem_ready=1 for 4 cycles -> pc 0,1,2,3,4; imem_req=1 throughout; flush=0.
REQ-032 pc=0x0010, branch_valid=1, salto=1, destino=0x0200 -> next cycle pc=0x0200, flush=1 for 2 cycles, imem_req=0; third cycle imem_req=1 with pc=0x0200.
REQ-033 branch_valid=1, salto=0, or branch_valid=0, salto=1 -> no flush; pc increments normally.
REQ-034 pc=0xFFFF, imem_ready=1 -> pc=0x0000; stall=1 with imem_ready=1 -> pc unchanged.
REQ-035 Second taken branch (destino=0x0300) in first FLUSH cycle -> pc=0x0300, flush stays high 2 more cycles; with BRANCH_COUNT_EN, contagem_saltos=2.
REQ-036 halt during FLUSH -> HALTED after flush; branch ignored while HALTED; resume -> fetch at held pc; reset mid-HALTED -> pc=RESET_PC, FETCH.
